// File: rtl/game_round_controller_if.sv
// Signal bundle between the round controller and its neighbours: LFSR and sensor
// inputs in, target/score/timer/audio status out.
interface game_round_controller_if;
    logic        start_game;
    logic [2:0]  lfsr_value;
    logic [2:0]  box_address;
    logic [2:0]  target_box;
    logic        target_valid;
    logic [10:0] score;
    logic [5:0]  game_timer;
    logic [1:0]  difficulty_level;
    logic        play_sound;
    logic        game_over;

    modport master (
        output start_game, lfsr_value, box_address,
        input  target_box, target_valid, score, game_timer,
               difficulty_level, play_sound, game_over
    );

    modport slave (
        input  start_game, lfsr_value, box_address,
        output target_box, target_valid, score, game_timer,
               difficulty_level, play_sound, game_over
    );
endinterface

// File: rtl/game_round_controller.sv
// Whack-a-mole round sequencer: picks a target box, runs a timed hit window,
// scores hits, and counts the game down second by second until game over.
module game_round_controller #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int GAME_SECONDS  = 60,
    parameter int WIN1          = 75000000,
    parameter int WIN2          = 50000000,
    parameter int WIN3          = 25000000,
    parameter int HOLD_CYCLES   = 12500000
) (
    input logic                    CLOCK_50,
    input logic                    reset,
    game_round_controller_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_ACTIVE, S_RESULT, S_GAMEOVER} state_t;

    localparam logic [25:0] SEC_LAST  = 26'(TICKS_PER_SEC - 1);
    localparam logic [26:0] WIN1_LAST = 27'(WIN1 - 1);
    localparam logic [26:0] WIN2_LAST = 27'(WIN2 - 1);
    localparam logic [26:0] WIN3_LAST = 27'(WIN3 - 1);
    localparam logic [26:0] HOLD_LAST = 27'(HOLD_CYCLES - 1);
    localparam logic [5:0]  GAME_SEC  = 6'(GAME_SECONDS);

    state_t      r_state, w_state_next;
    logic        r_start_q;
    logic [2:0]  r_box_q;
    logic [2:0]  r_target_box, w_target_next, w_target_out;
    logic [2:0]  r_prev_target, w_prev_next;
    logic [1:0]  r_rej_cnt, w_rej_next;
    logic [26:0] r_win_cnt, w_win_next, w_win_load;
    logic [25:0] r_sec_cnt, w_sec_next;
    logic [10:0] r_score, w_score_next;
    logic [5:0]  r_game_timer, w_timer_next;
    logic [1:0]  r_difficulty;
    logic        r_play_sound, w_sound_next;
    logic        r_target_valid;
    logic        r_game_over;
    logic        w_start_edge, w_hit_edge, w_in_game;
    logic [11:0] w_score_sum;

    function automatic logic [1:0] diff_of(input logic [5:0] timer);
        int elapsed;
        elapsed = GAME_SECONDS - int'(timer);
        if (elapsed < GAME_SECONDS / 3)
            return 2'd1;
        else if (elapsed < (2 * GAME_SECONDS) / 3)
            return 2'd2;
        return 2'd3;
    endfunction

    assign w_start_edge = bus.start_game & ~r_start_q;
    assign w_hit_edge   = (bus.box_address != 3'd0) && (r_box_q == 3'd0);
    assign w_in_game    = (r_state == S_PICK) || (r_state == S_ACTIVE) || (r_state == S_RESULT);
    assign w_score_sum  = {1'b0, r_score} + {10'd0, r_difficulty};

    always_comb begin
        case (r_difficulty)
            2'd2:    w_win_load = WIN2_LAST;
            2'd3:    w_win_load = WIN3_LAST;
            default: w_win_load = WIN1_LAST;
        endcase
    end

    // r_win_cnt doubles as the hit-window counter in ACTIVE and the blank-gap counter in RESULT.
    always_comb begin
        w_state_next  = r_state;
        w_score_next  = r_score;
        w_timer_next  = r_game_timer;
        w_sec_next    = r_sec_cnt;
        w_win_next    = r_win_cnt;
        w_rej_next    = r_rej_cnt;
        w_target_next = r_target_box;
        w_prev_next   = r_prev_target;
        w_sound_next  = 1'b0;

        if (w_in_game) begin
            if (r_sec_cnt == SEC_LAST) begin
                w_sec_next = 26'd0;
                if (r_game_timer != 6'd0)
                    w_timer_next = r_game_timer - 6'd1;
            end else begin
                w_sec_next = r_sec_cnt + 26'd1;
            end
        end

        case (r_state)
            S_IDLE, S_GAMEOVER: begin
                if (w_start_edge) begin
                    w_score_next = 11'd0;
                    w_timer_next = GAME_SEC;
                    w_sec_next   = 26'd0;
                    w_prev_next  = 3'd0;
                    w_rej_next   = 2'd0;
                    w_state_next = S_PICK;
                end
            end
            S_PICK: begin
                if (bus.lfsr_value == 3'd0) begin
                    w_rej_next = 2'd0;
                end else if ((bus.lfsr_value == r_prev_target) && (r_rej_cnt != 2'd3)) begin
                    w_rej_next = r_rej_cnt + 2'd1;
                end else begin
                    w_target_next = bus.lfsr_value;
                    w_prev_next   = bus.lfsr_value;
                    w_rej_next    = 2'd0;
                    w_win_next    = w_win_load;
                    w_state_next  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_hit_edge && (bus.box_address == r_target_box)) begin
                    w_score_next = w_score_sum[11] ? 11'd2047 : w_score_sum[10:0];
                    w_sound_next = 1'b1;
                    w_win_next   = HOLD_LAST;
                    w_state_next = S_RESULT;
                end else begin
                    if (w_hit_edge && (r_score != 11'd0))
                        w_score_next = r_score - 11'd1;
                    if (r_win_cnt == 27'd0) begin
                        w_win_next   = HOLD_LAST;
                        w_state_next = S_RESULT;
                    end else begin
                        w_win_next = r_win_cnt - 27'd1;
                    end
                end
            end
            S_RESULT: begin
                if (r_win_cnt == 27'd0) begin
                    w_rej_next   = 2'd0;
                    w_state_next = S_PICK;
                end else begin
                    w_win_next = r_win_cnt - 27'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Expiry overrides the round outcome, but any hit scored above still stands.
        if (w_in_game && (w_timer_next == 6'd0))
            w_state_next = S_GAMEOVER;
    end

    assign w_target_out = (w_state_next == S_ACTIVE) ? w_target_next : 3'd0;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_start_q      <= 1'b0;
            r_box_q        <= 3'd0;
            r_target_box   <= 3'd0;
            r_prev_target  <= 3'd0;
            r_rej_cnt      <= 2'd0;
            r_win_cnt      <= 27'd0;
            r_sec_cnt      <= 26'd0;
            r_score        <= 11'd0;
            r_game_timer   <= GAME_SEC;
            r_difficulty   <= 2'd1;
            r_play_sound   <= 1'b0;
            r_target_valid <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_start_q      <= bus.start_game;
            r_box_q        <= bus.box_address;
            r_target_box   <= w_target_out;
            r_prev_target  <= w_prev_next;
            r_rej_cnt      <= w_rej_next;
            r_win_cnt      <= w_win_next;
            r_sec_cnt      <= w_sec_next;
            r_score        <= w_score_next;
            r_game_timer   <= w_timer_next;
            r_difficulty   <= diff_of(w_timer_next);
            r_play_sound   <= w_sound_next;
            r_target_valid <= (w_state_next == S_ACTIVE);
            r_game_over    <= (w_state_next == S_GAMEOVER);
        end
    end

    assign bus.target_box       = r_target_box;
    assign bus.target_valid     = r_target_valid;
    assign bus.score            = r_score;
    assign bus.game_timer       = r_game_timer;
    assign bus.difficulty_level = r_difficulty;
    assign bus.play_sound       = r_play_sound;
    assign bus.game_over        = r_game_over;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed walk through a full game plus randomized play, checked every cycle
// against a game-level model (elapsed cycles, round phase, score arithmetic).
module tb_game_round_controller;
    localparam int T  = 10;
    localparam int G  = 6;
    localparam int W1 = 8;
    localparam int W2 = 6;
    localparam int W3 = 4;
    localparam int H  = 3;

    logic clk = 1'b0;
    logic rst;
    game_round_controller_if bus();

    game_round_controller #(
        .TICKS_PER_SEC(T), .GAME_SECONDS(G), .WIN1(W1), .WIN2(W2), .WIN3(W3), .HOLD_CYCLES(H)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Game-level model: a game is "running" or not; a round is picking, windowed or holding.
    bit m_run, m_over, m_pick, m_sound, m_pstart;
    int m_cyc, m_win, m_hold, m_score, m_target, m_prev, m_rej, m_pbox;

    function automatic int m_timer();
        return G - m_cyc / T;
    endfunction

    function automatic int m_diff();
        int e;
        e = G - m_timer();
        if (e < G / 3) return 1;
        if (e < 2 * G / 3) return 2;
        return 3;
    endfunction

    function automatic int win_len(input int d);
        if (d == 1) return W1;
        if (d == 2) return W2;
        return W3;
    endfunction

    function automatic int next_lfsr();
        return (m_prev % 7) + 1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_over = 0; m_pick = 0; m_sound = 0; m_pstart = 0;
        m_cyc = 0; m_win = 0; m_hold = 0; m_score = 0; m_target = 0;
        m_prev = 0; m_rej = 0; m_pbox = 0;
    endtask

    task automatic model_eval();
        bit se, he;
        int d, box, lf;
        box = int'(bus.box_address);
        lf  = int'(bus.lfsr_value);
        se = bus.start_game && !m_pstart;
        he = (box != 0) && (m_pbox == 0);
        m_sound = 0;
        if (!m_run) begin
            if (se) begin
                m_run = 1; m_over = 0; m_score = 0; m_cyc = 0;
                m_prev = 0; m_rej = 0; m_pick = 1; m_win = 0; m_hold = 0;
                $display("game start");
            end
        end else begin
            d = m_diff();
            if (m_pick) begin
                if (lf == 0) m_rej = 0;
                else if (lf == m_prev && m_rej < 3) m_rej++;
                else begin
                    m_target = lf; m_prev = lf; m_rej = 0; m_win = win_len(d); m_pick = 0;
                end
            end else if (m_win > 0) begin
                if (he && box == m_target) begin
                    m_score = (m_score + d > 2047) ? 2047 : m_score + d;
                    m_sound = 1; m_win = 0; m_hold = H;
                    $display("round hit box=%0d score=%0d", box, m_score);
                end else begin
                    if (he) m_score = (m_score > 0) ? m_score - 1 : 0;
                    m_win--;
                    if (m_win == 0) begin
                        m_hold = H;
                        $display("round miss target=%0d score=%0d", m_target, m_score);
                    end
                end
            end else begin
                m_hold--;
                if (m_hold == 0) begin m_pick = 1; m_rej = 0; end
            end
            m_cyc++;
            if (m_timer() == 0) begin
                m_run = 0; m_over = 1; m_pick = 0; m_win = 0; m_hold = 0;
                $display("game over score=%0d", m_score);
            end
        end
        m_pstart = bus.start_game;
        m_pbox   = box;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit act;
        act = m_run && (m_win > 0);
        check("target_box",   32'(bus.target_box), act ? m_target : 0);
        check("target_valid", 32'(bus.target_valid), 32'(act));
        check("score",        32'(bus.score), m_score);
        check("game_timer",   32'(bus.game_timer), m_timer());
        check("difficulty",   32'(bus.difficulty_level), m_diff());
        check("play_sound",   32'(bus.play_sound), 32'(m_sound));
        check("game_over",    32'(bus.game_over), 32'(m_over));
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int n, wlen, guard, sc, seen2;
        bit hit_done;
        rst = 1'b1;
        bus.start_game = 1'b0; bus.lfsr_value = 3'd0; bus.box_address = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("step reset released");
        check_all();
        check("rst_timer", 32'(bus.game_timer), 6);
        check("rst_diff", 32'(bus.difficulty_level), 1);

        // 1: start, pick 5, correct hit, blank gap then next pick
        $display("step start and correct hit");
        bus.start_game = 1; step();
        bus.start_game = 0; bus.lfsr_value = 3'd5; step();
        check("t1_target", 32'(bus.target_box), 5);
        bus.box_address = 3'd5; step();
        check("t1_score", 32'(bus.score), 1);
        check("t1_sound", 32'(bus.play_sound), 1);
        bus.box_address = 3'd0; bus.lfsr_value = 3'd3; step();
        check("t1_sound_off", 32'(bus.play_sound), 0);
        n = 1;
        while (bus.target_valid !== 1'b1 && n < 20) begin step(); n++; end
        check("t1_gap_cycles", n, 4);

        // 2: wrong hits floor at 0, window runs its full length
        $display("step wrong hit and timeout");
        check("t2_target", 32'(bus.target_box), 3);
        wlen = 1;
        bus.box_address = 3'd6; step(); if (bus.target_valid) wlen++;
        check("t2_score_dec", 32'(bus.score), 0);
        bus.box_address = 3'd0; step(); if (bus.target_valid) wlen++;
        bus.box_address = 3'd6; step(); if (bus.target_valid) wlen++;
        check("t2_score_floor", 32'(bus.score), 0);
        bus.box_address = 3'd0; bus.lfsr_value = 3'd0;
        guard = 0;
        while (bus.target_valid === 1'b1 && guard < 20) begin
            step(); guard++;
            if (bus.target_valid) wlen++;
        end
        check("t2_window_len", wlen, W1);

        // 3: zero and repeated-target rejection
        $display("step pick rejection");
        repeat (3) step();
        repeat (5) begin step(); check("t3_zero_reject", 32'(bus.target_valid), 0); end
        bus.lfsr_value = 3'd3;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t3_repeat", 32'(bus.target_valid), (i == 4) ? 1 : 0);
        end
        check("t3_target", 32'(bus.target_box), 3);

        // 4: difficulty steps, +3 hit, short window
        $display("step difficulty progression");
        guard = 0; seen2 = -1;
        while (bus.difficulty_level != 2'd3 && guard < 200) begin
            bus.lfsr_value  = 3'(next_lfsr());
            bus.box_address = (bus.target_valid && bus.box_address == 3'd0) ? bus.target_box : 3'd0;
            step(); guard++;
            if (bus.difficulty_level == 2'd2 && seen2 < 0) seen2 = int'(bus.game_timer);
        end
        bus.box_address = 3'd0;
        check("t4_diff2_at", seen2, 4);
        check("t4_diff3_at", 32'(bus.game_timer), 2);
        guard = 0;
        while (bus.target_valid !== 1'b1 && guard < 20) begin
            bus.lfsr_value = 3'(next_lfsr()); step(); guard++;
        end
        sc = int'(bus.score);
        bus.box_address = bus.target_box; step();
        check("t4_score_plus3", 32'(bus.score), sc + 3);
        bus.box_address = 3'd0;
        guard = 0;
        while (bus.target_valid !== 1'b1 && guard < 20) begin
            bus.lfsr_value = 3'(next_lfsr()); step(); guard++;
        end
        wlen = 0; guard = 0;
        while (bus.target_valid === 1'b1 && guard < 20) begin wlen++; step(); guard++; end
        check("t4_window3_len", wlen, W3);
        guard = 0;
        while (bus.game_over !== 1'b1 && guard < 100) begin
            bus.lfsr_value = 3'(next_lfsr()); step(); guard++;
        end
        check("t4_game_over", 32'(bus.game_over), 1);

        // 5: correct hit coinciding with expiry, frozen game, restart
        $display("step coincident hit at expiry");
        bus.start_game = 1; step(); bus.start_game = 0;
        hit_done = 0; guard = 0;
        while (!hit_done && guard < 100) begin
            bus.lfsr_value = (m_cyc < G * T - 4) ? 3'd0 : 3'(next_lfsr());
            if (m_run && m_win > 0 && m_cyc == G * T - 1) begin
                bus.box_address = 3'(m_target); hit_done = 1;
            end else begin
                bus.box_address = 3'd0;
            end
            step(); guard++;
        end
        check("t5_hit_reached", 32'(hit_done), 1);
        check("t5_score", 32'(bus.score), 3);
        check("t5_sound", 32'(bus.play_sound), 1);
        check("t5_over", 32'(bus.game_over), 1);
        check("t5_timer", 32'(bus.game_timer), 0);
        bus.box_address = 3'd0; step();
        bus.box_address = 3'd4; step();
        bus.box_address = 3'd0; step();
        check("t5_frozen", 32'(bus.score), 3);
        bus.start_game = 1; step(); bus.start_game = 0;
        check("t5_restart_score", 32'(bus.score), 0);
        check("t5_restart_timer", 32'(bus.game_timer), 6);

        // 6: asynchronous reset mid-window
        $display("step async reset mid game");
        guard = 0;
        while (bus.target_valid !== 1'b1 && guard < 20) begin
            bus.lfsr_value = 3'(next_lfsr()); step(); guard++;
        end
        bus.box_address = bus.target_box; step();
        bus.box_address = 3'd0;
        check("t6_score_before", 32'(bus.score), 1);
        guard = 0;
        while (bus.target_valid !== 1'b1 && guard < 20) begin
            bus.lfsr_value = 3'(next_lfsr()); step(); guard++;
        end
        #2 rst = 1'b1;
        #1;
        check("t6_score", 32'(bus.score), 0);
        check("t6_valid", 32'(bus.target_valid), 0);
        check("t6_target", 32'(bus.target_box), 0);
        check("t6_timer", 32'(bus.game_timer), 6);
        check("t6_diff", 32'(bus.difficulty_level), 1);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();
        bus.box_address = 3'd2; step();
        bus.box_address = 3'd0; step();
        check("t6_idle", 32'(bus.target_valid), 0);

        // randomized play
        $display("step randomized play");
        repeat (1500) begin
            bus.start_game = ($urandom_range(0, 29) == 0);
            bus.lfsr_value = 3'($urandom_range(0, 7));
            if (bus.box_address != 3'd0) begin
                if ($urandom_range(0, 2) == 0) bus.box_address = 3'd0;
            end else if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1 && bus.target_valid)
                    bus.box_address = bus.target_box;
                else
                    bus.box_address = 3'($urandom_range(1, 7));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences one whack-a-mole game: arms a target box from the LFSR, opens a timed hit window, classifies sensor hits as correct or wrong, and updates score and difficulty.
- Runs a per-second countdown and ends the game at zero.
- Sits between the LFSR and sensor-decode blocks and the score/HEX/audio outputs.
- Drives play_sound for the audio unit and target_box for the display path.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per game second.
- GAME_SECONDS, 60, game length in seconds; must be divisible by 3.
- WIN1, 75000000, hit-window length in cycles at difficulty 1.
- WIN2, 50000000, hit-window length in cycles at difficulty 2.
- WIN3, 25000000, hit-window length in cycles at difficulty 3.
- HOLD_CYCLES, 12500000, blank gap in cycles between rounds.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_game  in  1  level or pulse; a rising edge starts a game.
- lfsr_value  in  3  free-running LFSR output.
- box_address  in  3  decoded sensor box; 0 means no box pressed.
- target_box  out  3  currently armed box; 0 when none is armed.
- target_valid  out  1  high while the hit window is open.
- score  out  11  running score, saturating.
- game_timer  out  6  seconds remaining.
- difficulty_level  out  2  current difficulty, 1..3.
- play_sound  out  1  one-cycle pulse on a correct hit.
- game_over  out  1  high in the GAMEOVER state.

Behaviour:
- Reset values: all outputs clear; difficulty_level=1; game_timer=GAME_SECONDS; state=IDLE. Reset asserted mid-game aborts the game immediately.
- Edge detection: start_game and box_address are registered each cycle.
  - start_edge = start_game & ~start_q.
  - hit_edge = (box_address != 0) & (box_q == 0). A held press counts once; changing from one nonzero box to another does not count.
- States: IDLE, PICK, ACTIVE, RESULT, GAMEOVER.
- IDLE:
  - On start_edge: score=0, game_timer=GAME_SECONDS, sec_cnt=0, go to PICK.
  - Otherwise outputs hold their values.
- PICK (target_valid=0):
  - Reject lfsr_value==0: stay in PICK.
  - Reject lfsr_value==previous target: stay in PICK, at most 3 consecutive rejections; on the 4th such cycle accept anyway.
  - A zero value is always rejected.
  - On accept: target_box=lfsr_value, load win_cnt from WIN<difficulty>, go to ACTIVE. PICK therefore lasts at least 1 cycle.
- ACTIVE (target_valid=1, win_cnt decrements each cycle):
  - hit_edge with box_address==target_box:
    - score += difficulty_level, saturating at 2047.
    - play_sound=1 for exactly the next cycle.
    - Go to RESULT.
  - hit_edge with any other box:
    - score -= 1, floored at 0.
    - Stay in ACTIVE; the window keeps running.
  - win_cnt reaches 0 with no correct hit: miss, score unchanged, go to RESULT.
  - Hit and window expiry in the same cycle: the hit wins.
- RESULT:
  - target_valid=0, target_box=0.
  - Count HOLD_CYCLES, then go to PICK.
- Game clock:
  - sec_cnt counts 0..TICKS_PER_SEC-1 in PICK, ACTIVE and RESULT only.
  - On wrap, game_timer decrements.
  - elapsed = GAME_SECONDS - game_timer.
  - difficulty_level = 1 if elapsed < GAME_SECONDS/3; 2 if elapsed < 2*GAME_SECONDS/3; else 3.
  - A difficulty change takes effect at the next window load; an open window is not resized.
- Timer expiry:
  - When game_timer becomes 0, the next state is GAMEOVER from any game state.
  - A hit evaluated in the same cycle as expiry is still scored, and play_sound still pulses.
- GAMEOVER:
  - game_over=1, target_valid=0, target_box=0.
  - score is frozen; box_address is ignored.
  - On start_edge: restart exactly as from IDLE.
- start_game during PICK, ACTIVE or RESULT is ignored.
- Registers:
  - win_cnt is 27 bits; sec_cnt is 26 bits.
  - All outputs are registered; there is no combinational input-to-output path.

Test Plan:
Common bench parameters: TICKS_PER_SEC=10, GAME_SECONDS=6, WIN1=8, WIN2=6, WIN3=4, HOLD_CYCLES=3.
1. Start and correct hit: release reset, pulse start_game, force lfsr=5; press box 5 while ACTIVE -> target_box=5, score=1, play_sound high exactly 1 cycle, then RESULT for 3 cycles, then PICK.
2. Wrong hit then timeout: target=3; press box 6, release, let the window expire -> score decrements once, floored at 0; target_valid held for the 8-cycle window; score unchanged on timeout.
3. Rejection in PICK: lfsr holds 0 for 5 cycles -> stays in PICK. lfsr then equals the previous target for 4 cycles -> accepted on the 4th cycle.
4. Difficulty step: run past elapsed=2 s and 4 s -> difficulty_level goes 1->2->3; a correct hit then adds 3; WIN3=4 window observed.
5. Game end with coincident hit: correct hit in the cycle game_timer hits 0 -> score incremented, then game_over=1. Further presses change nothing. start_game edge -> score=0, game_timer=6.
6. Reset mid-ACTIVE: assert reset asynchronously between clock edges -> all outputs go immediately to reset values; state is IDLE.
